// File: rtl/mfp_adc_max10_arbiter_if.sv
// -----------------------------------------------------------------------------
// mfp_adc_max10_arbiter_if
// Avalon-ST command/response stream between the request arbiter and the
// MAX10 modular-ADC core.
//   master : arbiter side   (drives ADC_C_*, samples ADC_C_Ready and ADC_R_*)
//   slave  : adc_core side  (samples ADC_C_*, drives ADC_C_Ready and ADC_R_*)
// Signals:
//   ADC_C_Valid/Channel/SOP/EOP  command beat towards the ADC
//   ADC_C_Ready                  ADC accepts the command beat
//   ADC_R_Valid/Channel/Data     single-beat conversion result
//   ADC_R_SOP/EOP                framing of the result (always one beat)
// -----------------------------------------------------------------------------
interface mfp_adc_max10_arbiter_if;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;
  logic        ADC_R_SOP;
  logic        ADC_R_EOP;

  modport master (
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  ADC_C_Ready,
    input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP
  );

  modport slave (
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output ADC_C_Ready,
    output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP
  );
endinterface

// File: rtl/mfp_adc_max10_arbiter.sv
// -----------------------------------------------------------------------------
// mfp_adc_max10_arbiter
// Shares the single MAX10 ADC command/response stream between up to four
// requesters. Commands are granted round-robin, held in a one-entry output
// stage until the ADC takes them, and their requester index is kept in an
// in-order tag FIFO so each ADC response can be routed back to its issuer.
//
// Optional feature: define ADC_ARB_PRIORITY_EN to give requester 0 fixed top
// priority (the others stay round-robin among themselves).
//
// Ports:
//   CLK, RESET    clock and synchronous active-high reset
//   req_valid     per-requester command valid
//   req_channel   per-requester channel, requester i in [5i+4:5i]
//   req_ready     one-hot grant (combinational)
//   rsp_valid     one-hot, one-cycle response strobe (registered)
//   rsp_channel   channel of the routed response (registered)
//   rsp_data      sample of the routed response (registered)
//   err           sticky: orphan response or channel mismatch
//   adc           master side of the ADC command/response stream
// -----------------------------------------------------------------------------
module mfp_adc_max10_arbiter #(
  parameter int REQ_COUNT       = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [REQ_COUNT-1:0]     req_valid,
  input  logic [5*REQ_COUNT-1:0]   req_channel,
  output logic [REQ_COUNT-1:0]     req_ready,
  output logic [REQ_COUNT-1:0]     rsp_valid,
  output logic [4:0]               rsp_channel,
  output logic [11:0]              rsp_data,
  output logic                     err,
  mfp_adc_max10_arbiter_if.master  adc
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [1:0] LAST_RESET = 2'(REQ_COUNT - 1);

  logic                 stage_valid_r;
  logic [4:0]           stage_chan_r;
  logic [1:0]           stage_tag_r;
  logic [1:0]           last_grant_r;
  logic [1:0]           tag_mem_r  [MAX_OUTSTANDING];
  logic [4:0]           chan_mem_r [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     fifo_cnt_r;
  logic [REQ_COUNT-1:0] rsp_valid_r;
  logic [4:0]           rsp_channel_r;
  logic [11:0]          rsp_data_r;
  logic                 err_r;

  logic                 stage_free_s;
  logic [CNT_W-1:0]     out_cnt_s;
  logic                 grant_s;
  logic [1:0]           grant_idx_s;
  logic [2:0]           cand_s;
  logic [4:0]           grant_chan_s;
  logic [REQ_COUNT-1:0] req_ready_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 fifo_empty_s;
  logic [1:0]           head_tag_s;
  logic [4:0]           head_chan_s;
  logic [REQ_COUNT-1:0] rsp_onehot_s;
  logic                 unused_s;

  // Stage/FIFO bookkeeping shared by grant and update logic.
  assign stage_free_s = !stage_valid_r || adc.ADC_C_Ready;
  assign out_cnt_s    = fifo_cnt_r + CNT_W'(stage_valid_r);
  assign push_s       = stage_valid_r && adc.ADC_C_Ready;
  assign fifo_empty_s = (fifo_cnt_r == CNT_W'(0));
  assign pop_s        = adc.ADC_R_Valid && !fifo_empty_s;
  assign head_tag_s   = tag_mem_r[rd_ptr_r];
  assign head_chan_s  = chan_mem_r[rd_ptr_r];
  assign unused_s     = adc.ADC_R_SOP ^ adc.ADC_R_EOP;

  // Round-robin search from last_grant+1; outstanding count uses registered
  // state only, so a response frees a slot one cycle later.
  always_comb begin
    grant_s     = 1'b0;
    grant_idx_s = 2'd0;
    cand_s      = 3'd0;
`ifdef ADC_ARB_PRIORITY_EN
    if (req_valid[0]) begin
      grant_s     = 1'b1;
      grant_idx_s = 2'd0;
    end else begin
      grant_s     = 1'b0;
    end
`endif
    for (int off = 1; off <= REQ_COUNT; off++) begin
      cand_s = {1'b0, last_grant_r} + 3'(off);
      if (cand_s >= 3'(REQ_COUNT)) begin
        cand_s = cand_s - 3'(REQ_COUNT);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_s && req_valid[cand_s[1:0]]) begin
        grant_s     = 1'b1;
        grant_idx_s = cand_s[1:0];
      end else begin
        grant_s     = grant_s;
      end
    end
    if (!(stage_free_s && (out_cnt_s < CNT_W'(MAX_OUTSTANDING)) && !RESET)) begin
      grant_s = 1'b0;
    end else begin
      grant_s = grant_s;
    end
  end

  // Channel mux and one-hot decodes for grant and response routing.
  always_comb begin
    grant_chan_s = 5'd0;
    req_ready_s  = '0;
    rsp_onehot_s = '0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      if (grant_idx_s == 2'(i)) begin
        grant_chan_s = req_channel[5*i +: 5];
      end else begin
        grant_chan_s = grant_chan_s;
      end
      req_ready_s[i]  = grant_s && (grant_idx_s == 2'(i));
      rsp_onehot_s[i] = (head_tag_s == 2'(i));
    end
  end

  // Output stage and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stage_valid_r <= 1'b0;
      stage_chan_r  <= 5'd0;
      stage_tag_r   <= 2'd0;
      last_grant_r  <= LAST_RESET;
    end else begin
      if (stage_free_s) begin
        stage_valid_r <= grant_s;
        if (grant_s) begin
          stage_chan_r <= grant_chan_s;
          stage_tag_r  <= grant_idx_s;
        end
      end
`ifdef ADC_ARB_PRIORITY_EN
      if (grant_s && (grant_idx_s != 2'd0)) begin
        last_grant_r <= grant_idx_s;
      end
`else
      if (grant_s) begin
        last_grant_r <= grant_idx_s;
      end
`endif
    end
  end

  // In-order tag FIFO of commands the ADC has accepted.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      fifo_cnt_r <= CNT_W'(0);
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        tag_mem_r[i]  <= 2'd0;
        chan_mem_r[i] <= 5'd0;
      end
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r]  <= stage_tag_r;
        chan_mem_r[wr_ptr_r] <= stage_chan_r;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Response routing and sticky error flag.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rsp_valid_r   <= '0;
      rsp_channel_r <= 5'd0;
      rsp_data_r    <= 12'd0;
      err_r         <= 1'b0;
    end else begin
      rsp_valid_r <= '0;
      if (pop_s) begin
        rsp_valid_r   <= rsp_onehot_s;
        rsp_channel_r <= adc.ADC_R_Channel;
        rsp_data_r    <= adc.ADC_R_Data;
        if (adc.ADC_R_Channel != head_chan_s) begin
          err_r <= 1'b1;
        end
      end else if (adc.ADC_R_Valid) begin
        err_r <= 1'b1;
      end
    end
  end

  assign req_ready         = req_ready_s;
  assign rsp_valid         = rsp_valid_r;
  assign rsp_channel       = rsp_channel_r;
  assign rsp_data          = rsp_data_r;
  assign err               = err_r;
  assign adc.ADC_C_Valid   = stage_valid_r;
  assign adc.ADC_C_SOP     = stage_valid_r;
  assign adc.ADC_C_EOP     = stage_valid_r;
  assign adc.ADC_C_Channel = stage_chan_r;

endmodule
